// File: rtl/alu_arb.sv
// alu_arb: two-requester valid/ready arbiter in front of a shared
// combinational ALU.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rN_valid/rN_ready   requester handshakes (N = 0, 1)
//   rN_in1/in2/ctr      requester operands and op code
//   rsp_valid/ready     response handshake to the consumer
//   rsp_data/id/err     result, requester id, illegal-op flag
//   alu_in1/in2/ctr     drive the external ALU from operand registers
//   alu_out             combinational ALU result
// Macro ALU_ARB_ILLEGAL_CHK_EN: trap ops 10/13/14/15
// (result 0, err 1).
module alu_arb #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [WIDTH-1:0] r0_in1,
  input  logic [WIDTH-1:0] r0_in2,
  input  logic [3:0]       r0_ctr,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [WIDTH-1:0] r1_in1,
  input  logic [WIDTH-1:0] r1_in2,
  input  logic [3:0]       r1_ctr,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [3:0]       alu_ctr,
  input  logic [WIDTH-1:0] alu_out
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t state;
  state_t state_nxt;

  logic             last_id;
  logic             grant;
  logic             accept;
  logic             hshk;
  logic [WIDTH-1:0] op_in1;
  logic [WIDTH-1:0] op_in2;
  logic [3:0]       op_ctr;
  logic             op_id;
  logic [WIDTH-1:0] res_q;
  logic             err_q;
  logic             id_q;
  logic [WIDTH-1:0] res_nxt;
  logic             err_nxt;

  // Tie goes to the requester that was not served last.
  always_comb begin
    grant = 1'b0;
    if (r0_valid && r1_valid) begin
      grant = ~last_id;
    end else if (r1_valid) begin
      grant = 1'b1;
    end
  end

  assign r0_ready = (state == IDLE) && !rst && !grant;
  assign r1_ready = (state == IDLE) && !rst && grant;

  assign accept = (r0_valid && r0_ready) ||
                  (r1_valid && r1_ready);
  assign hshk   = (state == RESP) && rsp_ready;

  assign alu_in1 = op_in1;
  assign alu_in2 = op_in2;

`ifdef ALU_ARB_ILLEGAL_CHK_EN
  logic illegal;

  assign illegal = (op_ctr == 4'd10) ||
                   (op_ctr > 4'd12);

  // Park the ALU on a legal op while a trapped op executes.
  assign alu_ctr = ((state == EXEC) && illegal) ?
                   4'd0 : op_ctr;
  assign res_nxt = illegal ? '0 : alu_out;
  assign err_nxt = illegal;
`else
  assign alu_ctr = op_ctr;
  assign res_nxt = alu_out;
  assign err_nxt = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        state_nxt = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_in1  <= '0;
      op_in2  <= '0;
      op_ctr  <= '0;
      op_id   <= 1'b0;
      last_id <= 1'b1;
      res_q   <= '0;
      err_q   <= 1'b0;
      id_q    <= 1'b0;
    end else begin
      if (accept) begin
        op_in1 <= grant ? r1_in1 : r0_in1;
        op_in2 <= grant ? r1_in2 : r0_in2;
        op_ctr <= grant ? r1_ctr : r0_ctr;
        op_id  <= grant;
      end
      if (state == EXEC) begin
        res_q <= res_nxt;
        err_q <= err_nxt;
        id_q  <= op_id;
      end
      if (hshk) begin
        last_id <= id_q;
      end
    end
  end

  assign rsp_valid = (state == RESP);
  assign rsp_data  = res_q;
  assign rsp_err   = err_q;
  assign rsp_id    = id_q;

endmodule
